// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter that merges per-drive block requests onto one host block-device channel.
// The winning channel's LBA and operation are latched at grant; ack and buffer data follow grant.

module sd_block_arbiter #(
    parameter int unsigned   NCH     = 3,
    parameter int unsigned   TW      = 24,
    parameter logic [TW-1:0] TIMEOUT = 24'd1000000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [NCH*32-1:0] ch_lba,
    input  logic [NCH-1:0]    ch_rd,
    input  logic [NCH-1:0]    ch_wr,
    output logic [NCH-1:0]    ch_ack,
    input  logic [NCH*8-1:0]  ch_buff_din,
    output logic [31:0]       host_lba,
    output logic              host_rd,
    output logic              host_wr,
    input  logic              host_ack,
    output logic [7:0]        host_buff_din,
    output logic              busy,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    rr_q, rr_d;
    logic [31:0]   lba_q, lba_d;
    logic          op_wr_q, op_wr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          terr_q, terr_d;
    logic          old_ack_q;

    logic          req_found;
    logic [1:0]    req_idx;

    function automatic logic [1:0] wrap_idx(input int unsigned v);
        return 2'(v % NCH);
    endfunction

    // First requesting channel at or after the round-robin pointer.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!req_found && (ch_rd[wrap_idx(32'(rr_q) + k)] || ch_wr[wrap_idx(32'(rr_q) + k)])) begin
                req_found = 1'b1;
                req_idx   = wrap_idx(32'(rr_q) + k);
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_q      <= '0;
            lba_q     <= '0;
            op_wr_q   <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
            old_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            lba_q     <= lba_d;
            op_wr_q   <= op_wr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
            old_ack_q <= host_ack;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        lba_d   = lba_q;
        op_wr_d = op_wr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                rd_d = 1'b0;
                wr_d = 1'b0;
                if (req_found) begin
                    grant_d = req_idx;
                    lba_d   = ch_lba[32*req_idx +: 32];
                    // Read wins when both are set; the write stays pending.
                    op_wr_d = !ch_rd[req_idx];
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (host_ack && !old_ack_q) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = StXfer;
                end else if (!(rd_q || wr_q)) begin
                    // Issue cycle: the counter only runs while the request is presented.
                    rd_d = !op_wr_q;
                    wr_d = op_wr_q;
                end else if (cnt_q == TIMEOUT - 1'b1) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                    rr_d    = wrap_idx(32'(grant_q) + 32'd1);
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StXfer: begin
                if (old_ack_q && !host_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                rr_d    = wrap_idx(32'(grant_q) + 32'd1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q != StIdle);
        grant         = grant_q;
        host_lba      = lba_q;
        host_rd       = rd_q;
        host_wr       = wr_q;
        timeout_err   = terr_q;
        host_buff_din = busy ? ch_buff_din[8*grant_q +: 8] : 8'hFF;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_ack[i] = host_ack && (state_q == StReq || state_q == StXfer)
                        && (32'(grant_q) == i);
        end
    end

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Self-checking bench for sd_block_arbiter: directed scenarios with literal expectations,
// then randomized drive/host traffic compared every cycle against a transaction-level model.

module tb_sd_block_arbiter;

    localparam logic [23:0] TO = 24'd16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [95:0] ch_lba;
    logic [2:0]  ch_rd, ch_wr, ch_ack;
    logic [23:0] ch_buff_din;
    logic [31:0] host_lba;
    logic        host_rd, host_wr, host_ack;
    logic [7:0]  host_buff_din;
    logic        busy;
    logic [1:0]  grant;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    sd_block_arbiter #(.NCH(3), .TW(24), .TIMEOUT(TO)) dut (
        .clk_sys(clk), .reset_n(reset_n), .ch_lba(ch_lba), .ch_rd(ch_rd), .ch_wr(ch_wr),
        .ch_ack(ch_ack), .ch_buff_din(ch_buff_din), .host_lba(host_lba), .host_rd(host_rd),
        .host_wr(host_wr), .host_ack(host_ack), .host_buff_din(host_buff_din), .busy(busy),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: who owns the channel, how long its request has been out.
    localparam int PFREE = 0, PREQ = 1, PXFER = 2, PDONE = 3;
    int          m_phase = PFREE;
    int          m_ptr = 0, m_grant = 0, m_age = 0;
    logic [31:0] m_lba = '0;
    bit          m_is_wr = 0, m_hrd = 0, m_hwr = 0, m_terr = 0, m_prev = 0;
    bit          model_valid = 0;
    logic [2:0]  e_ack;
    logic [7:0]  e_din;
    bit          e_busy;

    // Called at the negedge; inputs then equal what the coming posedge samples.
    function automatic void model_step();
        bit rise, fall, found;
        int c;
        if (!reset_n) begin
            m_phase = PFREE; m_ptr = 0; m_grant = 0; m_age = 0; m_lba = '0;
            m_hrd = 0; m_hwr = 0; m_terr = 0; m_prev = 0;
            return;
        end
        rise   = host_ack && !m_prev;
        fall   = !host_ack && m_prev;
        m_terr = 0;
        found  = 0;
        case (m_phase)
            PFREE: begin
                m_hrd = 0; m_hwr = 0;
                for (int k = 0; k < 3; k++) begin
                    c = (m_ptr + k) % 3;
                    if (!found && (ch_rd[c] || ch_wr[c])) begin
                        found   = 1;
                        m_grant = c;
                        m_lba   = ch_lba[32*c +: 32];
                        m_is_wr = !ch_rd[c];
                        m_age   = 0;
                        m_phase = PREQ;
                    end
                end
            end
            PREQ: begin
                m_age++;
                if (rise) begin
                    m_hrd = 0; m_hwr = 0; m_phase = PXFER;
                end else if (m_age == 1) begin
                    m_hrd = !m_is_wr; m_hwr = m_is_wr;
                end else if (m_age == int'(TO) + 1) begin
                    m_hrd = 0; m_hwr = 0; m_terr = 1;
                    m_ptr = (m_grant + 1) % 3;
                    m_phase = PFREE;
                end
            end
            PXFER: if (fall) m_phase = PDONE;
            default: begin
                m_ptr = (m_grant + 1) % 3;
                m_phase = PFREE;
            end
        endcase
        m_prev = host_ack;
    endfunction

    initial forever begin
        @(negedge clk);
        if (model_valid) begin
            e_busy = (m_phase != PFREE);
            e_ack  = (host_ack && (m_phase == PREQ || m_phase == PXFER)) ?
                     3'(3'b001 << m_grant) : 3'b000;
            e_din  = e_busy ? ch_buff_din[8*m_grant +: 8] : 8'hFF;
            check("m_host_rd", 32'(host_rd), 32'(m_hrd));
            check("m_host_wr", 32'(host_wr), 32'(m_hwr));
            check("m_host_lba", host_lba, m_lba);
            check("m_busy", 32'(busy), 32'(e_busy));
            check("m_grant", 32'(grant), 32'(m_grant));
            check("m_timeout_err", 32'(timeout_err), 32'(m_terr));
            check("m_ch_ack", 32'(ch_ack), 32'(e_ack));
            check("m_buff_din", 32'(host_buff_din), 32'(e_din));
        end
        model_step();
        model_valid = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!(host_rd || host_wr) && n < 60) begin
            tick();
            n++;
        end
        check("wait_req", 32'(host_rd | host_wr), 32'd1);
    endtask

    task automatic expect_req(input int ch, input bit wr, input logic [31:0] lba);
        wait_req();
        check("req_grant", 32'(grant), 32'(ch));
        check("req_op", 32'({host_rd, host_wr}), wr ? 32'd1 : 32'd2);
        check("req_lba", host_lba, lba);
    endtask

    task automatic serve(input int ch, input bit clr_rd, input bit clr_wr);
        host_ack = 1'b1;
        #1;
        check("ack_route", 32'(ch_ack), 32'(3'(3'b001 << ch)));
        if (clr_rd) ch_rd[ch] = 1'b0;
        if (clr_wr) ch_wr[ch] = 1'b0;
        tick();
        check("req_drop", 32'({host_rd, host_wr}), 32'd0);
        tick();
        tick();
        host_ack = 1'b0;
        tick();
        check("busy_done", 32'(busy), 32'd1);
        tick();
        check("busy_free", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, pulses, hs, hd, hl;
        reset_n = 1'b0; ch_lba = '0; ch_rd = '0; ch_wr = '0; ch_buff_din = '0; host_ack = 1'b0;
        tick(); tick(); tick();
        check("rst_rdwr", 32'({host_rd, host_wr}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_lba", host_lba, 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_din", 32'(host_buff_din), 32'hFF);
        reset_n = 1'b1;
        tick();

        // Single read on ch1.
        ch_lba[63:32] = 32'h0000_0123;
        ch_rd[1] = 1'b1;
        tick();
        check("s1_lag_rd", 32'(host_rd), 32'd0);
        check("s1_lag_busy", 32'(busy), 32'd1);
        tick();
        check("s1_rd", 32'(host_rd), 32'd1);
        check("s1_lba", host_lba, 32'h123);
        serve(1, 1, 0);

        // All three from reset: served 0, 1, 2, then ch0 again.
        reset_n = 1'b0;
        ch_lba = {32'h0000_2222, 32'h0000_0123, 32'h0000_1000};
        ch_rd = 3'b111;
        tick(); tick();
        reset_n = 1'b1;
        expect_req(0, 0, 32'h1000); serve(0, 1, 0);
        expect_req(1, 0, 32'h0123); serve(1, 1, 0);
        expect_req(2, 0, 32'h2222); serve(2, 1, 0);
        ch_rd = 3'b011;
        expect_req(0, 0, 32'h1000); serve(0, 1, 0);
        expect_req(1, 0, 32'h0123); serve(1, 1, 0);

        // Write on ch2 with data routing.
        ch_buff_din = {8'hA5, 8'h22, 8'h11};
        ch_wr[2] = 1'b1;
        expect_req(2, 1, 32'h2222);
        host_ack = 1'b1;
        ch_wr[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3_din", 32'(host_buff_din), 32'hA5);
            check("s3_ack", 32'(ch_ack), 32'd4);
        end
        host_ack = 1'b0;
        tick(); tick();
        check("s3_free", 32'(busy), 32'd0);

        // Timeout on ch1 with ch2 pending.
        ch_rd = 3'b110;
        expect_req(1, 0, 32'h0123);
        cnt = 0; pulses = 0;
        while (host_rd && cnt < 40) begin
            if (timeout_err) pulses++;
            tick();
            cnt++;
        end
        check("to_len", 32'(cnt), 32'd16);
        check("to_early", 32'(pulses), 32'd0);
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        tick();
        check("to_pulse_end", 32'(timeout_err), 32'd0);
        check("to_next_grant", 32'(grant), 32'd2);
        expect_req(2, 0, 32'h2222); serve(2, 1, 0);
        expect_req(1, 0, 32'h0123); serve(1, 1, 0);

        // Reset during a transfer.
        ch_rd[0] = 1'b1;
        expect_req(0, 0, 32'h1000);
        host_ack = 1'b1;
        ch_rd[0] = 1'b0;
        tick(); tick();
        check("s5_xfer", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        check("s5_rdwr", 32'({host_rd, host_wr}), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_ack", 32'(ch_ack), 32'd0);
        reset_n = 1'b1;
        tick();
        check("s5_ack2", 32'(ch_ack), 32'd0);
        host_ack = 1'b0;
        tick();
        ch_rd[1] = 1'b1;
        expect_req(1, 0, 32'h0123); serve(1, 1, 0);

        // Read and write together on ch0; LBA re-latched for the write.
        ch_lba[31:0] = 32'h55;
        ch_rd[0] = 1'b1;
        ch_wr[0] = 1'b1;
        expect_req(0, 0, 32'h55);
        ch_lba[31:0] = 32'h66;
        tick();
        check("s6_lba_held", host_lba, 32'h55);
        serve(0, 1, 0);
        expect_req(0, 1, 32'h66);
        serve(0, 0, 1);

        // Randomized traffic; the model checks every cycle.
        hs = 0; hd = 0; hl = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0; host_ack = 1'b0; hs = 0;
            end else begin
                reset_n = 1'b1;
            end
            for (int c = 0; c < 3; c++) begin
                if (ch_ack[c]) begin
                    ch_rd[c] = 1'b0;
                    if ($urandom_range(0, 3) != 0) ch_wr[c] = 1'b0;
                end else if (!ch_rd[c] && !ch_wr[c] && $urandom_range(0, 7) == 0) begin
                    ch_rd[c] = 1'($urandom_range(0, 1));
                    ch_wr[c] = !ch_rd[c] || 1'($urandom_range(0, 1));
                    ch_lba[32*c +: 32] = $urandom;
                end
                if ($urandom_range(0, 7) == 0) ch_lba[32*c +: 32] = $urandom;
            end
            ch_buff_din = 24'($urandom);
            if (reset_n) begin
                case (hs)
                    0: begin
                        if (host_rd || host_wr) begin
                            hs = 1; hd = $urandom_range(0, 20);
                        end else if ($urandom_range(0, 49) == 0) begin
                            host_ack = 1'b1; hs = 3;
                        end
                    end
                    1: begin
                        if (!(host_rd || host_wr)) hs = 0;
                        else if (hd == 0) begin
                            host_ack = 1'b1; hl = $urandom_range(1, 6); hs = 2;
                        end else hd--;
                    end
                    2: begin
                        if (hl == 0) begin
                            host_ack = 1'b0; hs = 0;
                        end else hl--;
                    end
                    default: begin
                        host_ack = 1'b0; hs = 0;
                    end
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_block_arbiter.md
Name: sd_block_arbiter

Overview:
- Downstream of the emu-level disk logic: merges the per-drive block requests (floppy 1, HDD, floppy 2) into one host block-device channel.
- One request owns the host channel at a time.
- Grants go round-robin; the LBA and operation are latched at grant time.
- The host acknowledge and buffer-read data are routed only to/from the granted drive.
- A timeout frees the channel if the host never acknowledges.

Parameters:
NCH, 3, number of requesting channels (index 0 = floppy 1, 1 = HDD, 2 = floppy 2)
TIMEOUT, 24'd1000000, clk_sys cycles to wait in REQ for host_ack rise before abandoning
TW, 24, timeout counter width

Ports:
clk_sys  in  1  system clock
reset_n  in  1  synchronous active-low reset
ch_lba  in  NCH*32  per-channel LBA, channel i at [32*i+31:32*i]
ch_rd  in  NCH  per-channel read request level
ch_wr  in  NCH  per-channel write request level
ch_ack  out  NCH  per-channel acknowledge
ch_buff_din  in  NCH*8  per-channel write-data byte to host (drive buffer read-out)
host_lba  out  32  LBA presented to host
host_rd  out  1  host read request
host_wr  out  1  host write request
host_ack  in  1  host acknowledge (high for whole transfer)
host_buff_din  out  8  write data to host
busy  out  1  channel owned (state != IDLE)
grant  out  2  index of owning channel
timeout_err  out  1  one-cycle pulse on abandoned request

Behaviour:
- Reset (reset_n low at edge) forces:
  - state=IDLE; rr_ptr=0; grant=0; timeout counter=0.
  - host_rd=0, host_wr=0, host_lba=0, busy=0, timeout_err=0.
  - Reset mid-transfer drops host_rd/host_wr on that edge; no ack is forwarded afterwards.
- States: IDLE, REQ, XFER, DONE.
- IDLE:
  - Scan channels rr_ptr, rr_ptr+1, … (mod NCH); the first with ch_rd|ch_wr wins.
  - Latch grant, host_lba = ch_lba[grant], op.
  - If both rd and wr are set on the winning channel, read wins; the write stays pending for a later grant.
  - Next state REQ; host_rd/host_wr assert one cycle after the request is seen (registered).
  - No request: stay in IDLE, outputs unchanged except host_rd/host_wr = 0.
- REQ:
  - host_rd/host_wr held; counter increments every cycle.
  - host_ack rising edge (registered old_ack=0, host_ack=1): clear host_rd/host_wr on that edge, clear counter, go XFER.
  - Counter == TIMEOUT-1 without ack: clear host_rd/host_wr, pulse timeout_err for 1 cycle, rr_ptr = grant+1 mod NCH, go IDLE.
- XFER: host_ack falling edge → DONE. There is no timeout in XFER.
- DONE: one cycle; rr_ptr = grant+1 mod NCH; go IDLE. A new grant is therefore possible no earlier than 2 cycles after ack falls.
- Acknowledge routing (combinational):
  - ch_ack[i] = host_ack & (state is REQ or XFER) & (grant == i).
  - ch_ack is 0 for all channels in IDLE/DONE, including a stray host_ack.
- Data routing (combinational): host_buff_din = ch_buff_din[grant] while busy, else 8'hFF.
- busy = (state != IDLE). grant holds its value through DONE and until the next grant.
- The LBA is latched once per grant; ch_lba changes during REQ/XFER do not affect host_lba.
- Requests dropped by a channel while it is not granted are simply not seen. A request dropped while granted in REQ does not cancel the host transaction.
- The counter saturates logic at TIMEOUT-1; TW must hold TIMEOUT.

Test Plan:
- Single read on ch1, LBA 0x0000_0123:
  - host_rd=1 two cycles after ch_rd[1] rises; host_lba=0x123.
  - On host_ack high: ch_ack=3'b010 and host_rd=0 next edge.
  - ack low → busy=0 after 2 cycles.
- Simultaneous ch_rd=3'b111 from reset:
  - Grants are served in order 0, 1, 2, each after the previous DONE.
  - Re-raising ch0 after ch2 is served grants ch0 next.
- Write on ch2 with ch_buff_din[2]=8'hA5: host_wr=1; host_buff_din=8'hA5 during XFER; ch_ack[0] and ch_ack[1] stay 0 throughout.
- No host_ack with TIMEOUT=16:
  - host_rd drops exactly 16 cycles after asserting; timeout_err pulses once.
  - busy=0 next cycle; rr_ptr advances, so a pending ch2 wins over a repeated ch1.
- reset_n low during XFER: host_rd=host_wr=busy=0 after that edge; ch_ack=0 although host_ack still high; normal grant resumes after release.
- ch_rd[0]=ch_wr[0]=1 together: host_rd only first; after DONE, if ch_wr[0] is still high, a second grant issues host_wr with the re-latched LBA.
